// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encodings and reset vector.
package ifu_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'b00,
    ST_WAIT = 2'b01,
    ST_HOLD = 2'b10
  } ifu_state_e;

  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

  // Fetch addresses are always word aligned; low bits of any source are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding memory request, output register held until decode accepts.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        inst_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  ifu_state_e  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        drop_q, drop_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;
  logic        err_q, err_d;
  logic        req_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_REQ;
      fetch_pc_q <= word_align(RESET_PC);
      drop_q     <= 1'b0;
      inst_q     <= 32'h0;
      pc_q       <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
      inst_q     <= inst_d;
      pc_q       <= pc_d;
      err_q      <= err_d;
    end
  end

  // Redirect is checked first in every state so it overrides fires and responses.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    inst_d     = inst_q;
    pc_d       = pc_q;
    err_d      = err_q;
    req_fire   = (state_q == ST_REQ) && imem_req_ready;

    case (state_q)
      ST_REQ: begin
        if (redirect_valid) begin
          fetch_pc_d = word_align(redirect_pc);
          if (req_fire) begin
            drop_d  = 1'b1;
            state_d = ST_WAIT;
          end
        end else if (req_fire) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          fetch_pc_d = word_align(redirect_pc);
          if (imem_rsp_valid) begin
            drop_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            drop_d = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            inst_d  = imem_rsp_data;
            err_d   = imem_rsp_err;
            pc_d    = fetch_pc_q;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          fetch_pc_d = word_align(redirect_pc);
          state_d    = ST_REQ;
        end else if (inst_ready) begin
          fetch_pc_d = word_align(pc_q + 32'd4);
          state_d    = ST_REQ;
        end
      end
      default: begin
        state_d = ST_REQ;
        drop_d  = 1'b0;
      end
    endcase
  end

  assign imem_req_valid = (state_q == ST_REQ) && !rst;
  assign imem_addr      = fetch_pc_q;
  assign inst_valid     = (state_q == ST_HOLD) && !rst;
  assign inst           = inst_q;
  assign pc             = pc_q;
  assign inst_err       = err_q;

endmodule

// File: tb/tb_ifu.sv
// Directed cycle-by-cycle bench for ifu: each vector drives one cycle and checks the outputs seen in it.
module tb_ifu;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        inst_ready;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        e_req_valid;
    logic [31:0] e_addr;
    logic        e_inst_valid;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    logic        e_err;
  } vec_t;

  vec_t table_v[$];

  ifu #(.RESET_PC(32'h8000_0000)) dut (
    .clk(clk),
    .rst(rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .imem_rsp_err(imem_rsp_err),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst(inst),
    .pc(pc),
    .inst_err(inst_err),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic rdy, input logic rv, input logic [31:0] rd,
                              input logic re, input logic ir, input logic dv, input logic [31:0] dp,
                              input logic e_rv, input logic [31:0] e_a, input logic e_iv,
                              input logic [31:0] e_i, input logic [31:0] e_p, input logic e_e);
    vec_t v;
    v.rst = r; v.req_ready = rdy; v.rsp_valid = rv; v.rsp_data = rd; v.rsp_err = re;
    v.inst_ready = ir; v.redir_valid = dv; v.redir_pc = dp;
    v.e_req_valid = e_rv; v.e_addr = e_a; v.e_inst_valid = e_iv;
    v.e_inst = e_i; v.e_pc = e_p; v.e_err = e_e;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst            = v.rst;
    imem_req_ready = v.req_ready;
    imem_rsp_valid = v.rsp_valid;
    imem_rsp_data  = v.rsp_data;
    imem_rsp_err   = v.rsp_err;
    inst_ready     = v.inst_ready;
    redirect_valid = v.redir_valid;
    redirect_pc    = v.redir_pc;
  endtask

  task automatic checkField(input string name, input string field, input logic [31:0] act,
                            input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s.%s: got %h, expected %h", name, field, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input vec_t v);
    checkField(name, "imem_req_valid", {31'h0, imem_req_valid}, {31'h0, v.e_req_valid});
    checkField(name, "imem_addr", imem_addr, v.e_addr);
    checkField(name, "inst_valid", {31'h0, inst_valid}, {31'h0, v.e_inst_valid});
    checkField(name, "inst", inst, v.e_inst);
    checkField(name, "pc", pc, v.e_pc);
    checkField(name, "inst_err", {31'h0, inst_err}, {31'h0, v.e_err});
  endtask

  // Drive inputs just after the falling edge, sample mid-cycle, then let the rising edge act.
  task automatic runVec(input string name, input vec_t v);
    @(negedge clk);
    applyStimulus(v);
    #1;
    checkOutput(name, v);
  endtask

  initial begin
    applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);

    // Reset, sequential fetch, redirect on a request fire, error response, ignored stray response.
    table_v.push_back(mk(1,0,0,32'h0,0,0,0,32'h0,           0,32'h8000_0000,0,32'h0,32'h0,0));
    table_v.push_back(mk(0,1,0,32'h0,0,0,0,32'h0,           1,32'h8000_0000,0,32'h0,32'h0,0));
    table_v.push_back(mk(0,0,1,32'h0000_0013,0,0,0,32'h0,   0,32'h8000_0000,0,32'h0,32'h0,0));
    table_v.push_back(mk(0,0,0,32'h0,0,1,0,32'h0,           0,32'h8000_0000,1,32'h0000_0013,32'h8000_0000,0));
    table_v.push_back(mk(0,1,0,32'h0,0,0,0,32'h0,           1,32'h8000_0004,0,32'h0000_0013,32'h8000_0000,0));
    table_v.push_back(mk(0,0,1,32'h0010_0093,0,0,0,32'h0,   0,32'h8000_0004,0,32'h0000_0013,32'h8000_0000,0));
    table_v.push_back(mk(0,0,0,32'h0,0,1,0,32'h0,           0,32'h8000_0004,1,32'h0010_0093,32'h8000_0004,0));
    table_v.push_back(mk(0,1,0,32'h0,0,0,1,32'h8000_0100,   1,32'h8000_0008,0,32'h0010_0093,32'h8000_0004,0));
    table_v.push_back(mk(0,0,1,32'h0000_0013,0,1,0,32'h0,   0,32'h8000_0100,0,32'h0010_0093,32'h8000_0004,0));
    table_v.push_back(mk(0,1,0,32'h0,0,0,0,32'h0,           1,32'h8000_0100,0,32'h0010_0093,32'h8000_0004,0));
    table_v.push_back(mk(0,0,1,32'h0000_0013,1,0,0,32'h0,   0,32'h8000_0100,0,32'h0010_0093,32'h8000_0004,0));
    table_v.push_back(mk(0,0,0,32'h0,0,1,0,32'h0,           0,32'h8000_0100,1,32'h0000_0013,32'h8000_0100,1));
    table_v.push_back(mk(0,0,0,32'h0,0,0,0,32'h0,           1,32'h8000_0104,0,32'h0000_0013,32'h8000_0100,1));
    table_v.push_back(mk(0,0,1,32'hDEAD_BEEF,0,0,0,32'h0,   1,32'h8000_0104,0,32'h0000_0013,32'h8000_0100,1));
    table_v.push_back(mk(0,1,0,32'h0,0,0,0,32'h0,           1,32'h8000_0104,0,32'h0000_0013,32'h8000_0100,1));
    table_v.push_back(mk(0,0,0,32'h0,0,0,0,32'h0,           0,32'h8000_0104,0,32'h0000_0013,32'h8000_0100,1));
    table_v.push_back(mk(0,0,1,32'h0000_0073,0,0,0,32'h0,   0,32'h8000_0104,0,32'h0000_0013,32'h8000_0100,1));

    foreach (table_v[i]) runVec($sformatf("vec%0d", i), table_v[i]);

    // Decode stall in HOLD: outputs frozen and no request until the fire.
    for (int i = 0; i < 5; i++)
      runVec($sformatf("stall%0d", i),
             mk(0,1,0,32'h0,0,0,0,32'h0, 0,32'h8000_0104,1,32'h0000_0073,32'h8000_0104,0));
    runVec("stall_fire", mk(0,1,0,32'h0,0,1,0,32'h0, 0,32'h8000_0104,1,32'h0000_0073,32'h8000_0104,0));
    runVec("after_stall", mk(0,1,0,32'h0,0,0,0,32'h0, 1,32'h8000_0108,0,32'h0000_0073,32'h8000_0104,0));
    runVec("rsp_108", mk(0,0,1,32'h0000_0033,0,0,0,32'h0, 0,32'h8000_0108,0,32'h0000_0073,32'h8000_0104,0));

    // Redirect in HOLD with misaligned target, redirect in REQ without fire, pc+4 wrap.
    runVec("hold_redir", mk(0,0,0,32'h0,0,0,1,32'h8000_0203, 0,32'h8000_0108,1,32'h0000_0033,32'h8000_0108,0));
    runVec("req_redir", mk(0,0,0,32'h0,0,0,1,32'hFFFF_FFFE, 1,32'h8000_0200,0,32'h0000_0033,32'h8000_0108,0));
    runVec("wrap_req", mk(0,1,0,32'h0,0,0,0,32'h0, 1,32'hFFFF_FFFC,0,32'h0000_0033,32'h8000_0108,0));
    runVec("wrap_rsp", mk(0,0,1,32'h0000_0001,0,0,0,32'h0, 0,32'hFFFF_FFFC,0,32'h0000_0033,32'h8000_0108,0));
    runVec("wrap_hold", mk(0,0,0,32'h0,0,1,0,32'h0, 0,32'hFFFF_FFFC,1,32'h0000_0001,32'hFFFF_FFFC,0));
    runVec("wrap_next", mk(0,1,0,32'h0,0,0,0,32'h0, 1,32'h0000_0000,0,32'h0000_0001,32'hFFFF_FFFC,0));

    // Redirect in WAIT together with a response: discarded, straight back to REQ.
    runVec("wait_redir", mk(0,0,1,32'h0000_0BAD,0,1,1,32'h8000_0040, 0,32'h0000_0000,0,32'h0000_0001,32'hFFFF_FFFC,0));
    runVec("after_wredir", mk(0,1,0,32'h0,0,0,0,32'h0, 1,32'h8000_0040,0,32'h0000_0001,32'hFFFF_FFFC,0));

    // Reset in WAIT; the late response lands in REQ and must be ignored.
    runVec("rst_in_wait", mk(1,0,0,32'h0,0,0,0,32'h0, 0,32'h8000_0040,0,32'h0000_0001,32'hFFFF_FFFC,0));
    runVec("late_rsp", mk(0,0,1,32'h0000_0BAD,1,1,0,32'h0, 1,32'h8000_0000,0,32'h0,32'h0,0));
    runVec("after_late", mk(0,0,0,32'h0,0,0,0,32'h0, 1,32'h8000_0000,0,32'h0,32'h0,0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
